// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) memory arbiter with round-robin tie-break and a bounded wait for mem_ready.
// Every output is a flop; the next-state/next-output logic is one combinational block.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_data_q, last_data_d;
  logic              gnt_data_q, gnt_data_d;
  logic              pick_data;

  logic              mem_rd_d, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              f_ack_d, d_ack_d, err_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b0;
      gnt_data_q  <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      f_ack       <= 1'b0;
      d_ack       <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      mem_rd      <= mem_rd_d;
      mem_wr      <= mem_wr_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      rdata       <= rdata_d;
      f_ack       <= f_ack_d;
      d_ack       <= d_ack_d;
      err         <= err_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    pick_data   = 1'b0;
    mem_rd_d    = mem_rd;
    mem_wr_d    = mem_wr;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rdata_d     = rdata;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          // On a tie, data wins unless data was the previous grant
          pick_data   = d_req && (!f_req || !last_data_q);
          gnt_data_d  = pick_data;
          mem_addr_d  = pick_data ? d_addr : f_addr;
          mem_rd_d    = !(pick_data && d_we);
          mem_wr_d    = pick_data && d_we;
          if (pick_data) begin
            mem_wdata_d = d_wdata;
          end
          cnt_d       = '0;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_ready) begin
          rdata_d     = mem_wr ? '0 : mem_rdata;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          f_ack_d     = !gnt_data_q;
          d_ack_d     = gnt_data_q;
          last_data_d = gnt_data_q;
          state_d     = S_ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d     = '0;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          f_ack_d     = !gnt_data_q;
          d_ack_d     = gnt_data_q;
          err_d       = 1'b1;
          last_data_d = gnt_data_q;
          state_d     = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
